if_fetch_unit: RTL

- Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register.
- Owns the PC and issues in-order requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small fetch queue and presents pc/instr/pc+4 to IF/ID.
- Honours ID_redo (hold) and branch_flush (redirect), discarding stale in-flight responses.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_queue.sv | 81 ++++++++
 rtl/if_fetch_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   BUBBLE_INSTR     : instruction word presented when IF/ID receives a bubble
//   DEFAULT_RESET_PC : default first fetch address after reset
//   fetch_entry_t    : one fetch-queue entry, {pc, instr}
//   cnt_width()      : width of a counter that must hold 0..depth inclusive
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [31:0] BUBBLE_INSTR     = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // A counter of queued or outstanding fetches has to reach the depth itself,
  // not just depth-1, hence the +1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Small synchronous FIFO of fetch_entry_t used as the fetch buffer.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   push, push_data : enqueue one entry (ignored when full unless popping)
//   pop             : dequeue the head entry (ignored when empty)
//   clear           : drop every entry; wins over push and pop
//   head            : current head entry (only meaningful when !empty)
//   full, empty     : occupancy flags
//   count           : number of entries held
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          clear,
  output fetch_entry_t  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage feeding the IF/ID register. Owns the PC, issues
// in-order requests over a req/gnt/rvalid interface, buffers responses in a
// fetch queue and presents {pc, instr, pc+4} of the queue head.
// Ports:
//   clk_i, rst_i                 : clock, asynchronous active-low reset
//   branch_flush, branch_target_i: redirect from EX (target bits [1:0] ignored)
//   ID_redo                      : downstream hold of the presented entry
//   imem_req_o, imem_addr_o      : fetch request and address (current PC)
//   imem_gnt_i                   : request accepted this cycle
//   imem_rvalid_i, imem_rdata_i  : in-order response
//   valid_o, pc_o, instr_o,
//   pc_add4_o                    : presented instruction (zeros when bubble)
// Optional build macro FETCH_PERF_CNT_EN adds:
//   fetch_cnt_o                  : saturating count of consumed instructions
//   bubble_cnt_o                 : saturating count of cycles with valid_o=0
//                                  while ID is not holding
// -----------------------------------------------------------------------------
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_flush,
  input  logic [31:0] branch_target_i,
  input  logic        ID_redo,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_add4_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  localparam int CW = cnt_width(QUEUE_DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   rsp_pc_q;
  logic [CW-1:0] inflight_q;
  logic [CW-1:0] inflight_d;
  logic [CW-1:0] discard_q;
  logic [CW-1:0] discard_d;
  logic [CW-1:0] q_count;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_pc;
  logic          q_full;
  logic          q_empty;
  logic          issue;
  logic          rsp_taken;
  logic          q_push;
  logic          q_pop;
  fetch_entry_t  q_head;
  fetch_entry_t  q_push_data;

  assign redirect_pc = branch_target_i & ~32'h3;

  // Credit covers everything queued plus everything still owed by memory,
  // including responses already marked for discard, so the queue can never
  // overflow and the discard counter never exceeds the depth. Request is
  // forced low while reset is held.
  assign credit_used = {1'b0, q_count} + {1'b0, inflight_q};
  assign imem_req_o  = rst_i && !branch_flush && !q_full &&
                       (credit_used < (CW+1)'(QUEUE_DEPTH));
  assign imem_addr_o = pc_q;
  assign issue       = imem_req_o && imem_gnt_i;

  // A response is consumed from the outstanding count whenever one arrives.
  assign rsp_taken   = imem_rvalid_i && (inflight_q != '0);

  // Live responses arrive in PC order starting at the last redirect, so
  // rsp_pc_q tracks the address of the next live response without a PC FIFO.
  assign q_push      = rsp_taken && (discard_q == '0) && !branch_flush;
  assign q_pop       = valid_o && !ID_redo && !branch_flush;
  assign q_push_data = '{pc: rsp_pc_q, instr: imem_rdata_i};

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .CW    (CW)
  ) u_queue (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .clear     (branch_flush),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign valid_o   = !q_empty;
  assign pc_o      = q_empty ? 32'h0 : q_head.pc;
  assign instr_o   = q_empty ? BUBBLE_INSTR : q_head.instr;
  assign pc_add4_o = q_empty ? 32'h0 : q_head.pc + 32'd4;

  // inflight_q counts every request still owed by memory, stale or not.
  // On a flush all of them become stale, so discard takes the whole
  // outstanding count minus any response consumed in the flush cycle; this
  // equals the old discard plus the live in-flight requests.
  always_comb begin
    inflight_d = inflight_q;
    discard_d  = discard_q;
    if (issue) begin
      inflight_d = inflight_d + CW'(1);
    end
    if (rsp_taken) begin
      inflight_d = inflight_d - CW'(1);
    end
    if (branch_flush) begin
      discard_d = rsp_taken ? inflight_q - CW'(1) : inflight_q;
    end else if (rsp_taken && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      if (branch_flush) begin
        pc_q     <= redirect_pc;
        rsp_pc_q <= redirect_pc;
      end else begin
        if (issue) begin
          pc_q <= pc_q + 32'd4;
        end
        if (q_push) begin
          rsp_pc_q <= rsp_pc_q + 32'd4;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // An entry squashed by a flush is not counted as fetched.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (q_pop && (fetch_cnt_o != 32'hFFFF_FFFF)) begin
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
      end
      if (!valid_o && !ID_redo && (bubble_cnt_o != 32'hFFFF_FFFF)) begin
        bubble_cnt_o <= bubble_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
